// File: rtl/fp64_div_seq.sv
// Sequential IEEE-754 binary64 divider: radix-2 restoring, one quotient bit per clock,
// round-to-nearest-even, denormals flushed to zero, start/done handshake.
module fp64_div_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int EXP_WIDTH  = 11,
    parameter int FRAC_WIDTH = 52
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic [DATA_WIDTH-1:0] out_reg,
    output logic                  divizion_by_zero_reg,
    output logic                  nan_reg,
    output logic                  overflow_reg,
    output logic                  underflow_reg,
    output logic                  zero_reg,
    output logic                  done_reg
);
    localparam int EW = EXP_WIDTH + 2;
    localparam int MW = FRAC_WIDTH + 1;
    localparam int QW = MW + 2;
    localparam logic [EW-1:0] BIAS    = EW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [EW-1:0] EXP_INF = EW'((1 << EXP_WIDTH) - 1);
    localparam logic [5:0]    LAST_IT = 6'(QW - 1);
    localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SPECIAL, DIVIDE, ROUND} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic                    sign_q, sign_d;
    logic [EW-1:0]           exp_q, exp_d;
    logic [QW-1:0]           rem_q, rem_d;
    logic [MW-1:0]           div_q, div_d;
    logic [QW-1:0]           quo_q, quo_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    dz_q, dz_d, nan_q, nan_d, ovf_q, ovf_d;
    logic                    unf_q, unf_d, zero_q, zero_d, done_q, done_d;

    logic [EXP_WIDTH-1:0]    aExp, bExp;
    logic [FRAC_WIDTH-1:0]   aFrac, bFrac;
    logic                    aZero, bZero, aInf, bInf, aNan, bNan, isNan;
    logic [MW-1:0]           m1, m2;
    logic [EW-1:0]           expDiff, expRnd;
    logic [QW-1:0]           remSub;
    logic [MW:0]             mantSum;
    logic [MW-1:0]           mantFinal;
    logic                    roundUp;

    assign aExp  = a_q[DATA_WIDTH-2 -: EXP_WIDTH];
    assign bExp  = b_q[DATA_WIDTH-2 -: EXP_WIDTH];
    assign aFrac = a_q[FRAC_WIDTH-1:0];
    assign bFrac = b_q[FRAC_WIDTH-1:0];
    assign aZero = (aExp == '0);
    assign bZero = (bExp == '0);
    assign aInf  = (aExp == '1) && (aFrac == '0);
    assign bInf  = (bExp == '1) && (bFrac == '0);
    assign aNan  = (aExp == '1) && (aFrac != '0);
    assign bNan  = (bExp == '1) && (bFrac != '0);
    assign isNan = aNan || bNan || (aZero && bZero) || (aInf && bInf);
    assign m1    = {1'b1, aFrac};
    assign m2    = {1'b1, bFrac};
    assign expDiff = {2'b00, aExp} - {2'b00, bExp} + BIAS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            nan_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            nan_q   <= nan_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        rem_d     = rem_q;
        div_d     = div_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        dz_d      = dz_q;
        nan_d     = nan_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        remSub    = rem_q - {2'b00, div_q};
        roundUp   = quo_q[1] & (quo_q[0] | (rem_q != '0) | quo_q[2]);
        mantSum   = {1'b0, quo_q[QW-1:2]} + {{MW{1'b0}}, roundUp};
        mantFinal = mantSum[MW] ? mantSum[MW:1] : mantSum[MW-1:0];
        expRnd    = exp_q + EW'(mantSum[MW]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op1;
                    b_d     = op2;
                    state_d = SPECIAL;
                end
            end
            SPECIAL: begin
                done_d  = 1'b1;
                state_d = IDLE;
                sign_d  = a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];
                dz_d    = !aZero && bZero;
                nan_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                zero_d  = 1'b0;
                if (isNan) begin
                    res_d = QNAN;
                    nan_d = 1'b1;
                end else if (bZero || aInf) begin
                    res_d = {sign_d, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
                end else if (aZero || bInf) begin
                    res_d  = {sign_d, {(DATA_WIDTH-1){1'b0}}};
                    zero_d = 1'b1;
                end else begin
                    // Pre-normalise so the first quotient bit is always the leading 1
                    done_d  = 1'b0;
                    res_d   = res_q;
                    dz_d    = dz_q;
                    nan_d   = nan_q;
                    ovf_d   = ovf_q;
                    unf_d   = unf_q;
                    zero_d  = zero_q;
                    state_d = DIVIDE;
                    div_d   = m2;
                    quo_d   = '0;
                    cnt_d   = '0;
                    if (m1 < m2) begin
                        rem_d = {1'b0, m1, 1'b0};
                        exp_d = expDiff - EW'(1);
                    end else begin
                        rem_d = {2'b00, m1};
                        exp_d = expDiff;
                    end
                end
            end
            DIVIDE: begin
                if (rem_q >= {2'b00, div_q}) begin
                    quo_d = {quo_q[QW-2:0], 1'b1};
                    rem_d = {remSub[QW-2:0], 1'b0};
                end else begin
                    quo_d = {quo_q[QW-2:0], 1'b0};
                    rem_d = {rem_q[QW-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_IT) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                done_d  = 1'b1;
                state_d = IDLE;
                dz_d    = 1'b0;
                nan_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                zero_d  = 1'b0;
                // Top bit of expRnd set means the biased exponent went negative
                if (!expRnd[EW-1] && (expRnd >= EXP_INF)) begin
                    res_d = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
                    ovf_d = 1'b1;
                end else if (expRnd[EW-1] || (expRnd == '0)) begin
                    res_d  = {sign_q, {(DATA_WIDTH-1){1'b0}}};
                    unf_d  = 1'b1;
                    zero_d = 1'b1;
                end else begin
                    res_d = {sign_q, expRnd[EXP_WIDTH-1:0], mantFinal[FRAC_WIDTH-1:0]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_reg              = res_q;
    assign divizion_by_zero_reg = dz_q;
    assign nan_reg              = nan_q;
    assign overflow_reg         = ovf_q;
    assign underflow_reg        = unf_q;
    assign zero_reg             = zero_q;
    assign done_reg             = done_q;
endmodule
